// File: rtl/comma_aligner_10b_pkg.sv
// rtl/comma_aligner_10b_pkg.sv - shared constants, state type and helpers for the 10b comma aligner
package comma_aligner_10b_pkg;

    // K28.5 in both running disparities, bit a in [9], bit j in [0]
    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/comma_aligner_10b_sym_disparity_chk.sv
// rtl/comma_aligner_10b_sym_disparity_chk.sv - combinational symbol ones-count, disparity and comma check
//
// Ports:
//   sym      in  10  candidate symbol {abcdei,fghj}
//   rd       in  1   running disparity before sym (0 = RD-, 1 = RD+)
//   rd_next  out 1   running disparity after sym
//   code_err out 1   illegal ones count or disparity violation
//   is_comma out 1   sym is K28.5 of either disparity
module comma_aligner_10b_sym_disparity_chk
    import comma_aligner_10b_pkg::*;
(
    input  logic [9:0] sym,
    input  logic       rd,
    output logic       rd_next,
    output logic       code_err,
    output logic       is_comma
);

    logic [3:0] ones;

    always_comb begin
        ones     = popcount10(sym);
        rd_next  = rd;
        code_err = 1'b0;
        case (ones)
            4'd5: rd_next = rd;
            // unbalanced symbols still flip rd even when they arrive at the wrong disparity
            4'd6: begin
                rd_next  = 1'b1;
                code_err = rd;
            end
            4'd4: begin
                rd_next  = 1'b0;
                code_err = ~rd;
            end
            default: code_err = 1'b1;
        endcase
        is_comma = (sym == K28_5_NEG) || (sym == K28_5_POS);
    end

endmodule

// File: rtl/comma_aligner_10b.sv
// rtl/comma_aligner_10b.sv - serial K28.5 word aligner with running-disparity tracking and lock FSM
//
// Ports:
//   clk        in  1   clock, rising edge
//   rst        in  1   synchronous active-low reset
//   bit_in     in  1   serial line bit, first bit of a symbol ends up in sym_out[9]
//   bit_valid  in  1   qualifies bit_in; all state holds while low
//   sym_out    out 10  aligned symbol for the decoder
//   rd_out     out 1   running disparity before sym_out
//   sym_valid  out 1   one-cycle strobe for sym_out/rd_out/is_comma/code_err
//   is_comma   out 1   sym_out is K28.5
//   code_err   out 1   sym_out has a bad ones count or disparity
//   locked     out 1   aligner is in LOCKED
module comma_aligner_10b
    import comma_aligner_10b_pkg::*;
#(
    parameter int LOCK_COMMAS = 3,
    parameter int LOSS_ERRORS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [9:0] sym_out,
    output logic       rd_out,
    output logic       sym_valid,
    output logic       is_comma,
    output logic       code_err,
    output logic       locked
);

    localparam int CW = $clog2(LOCK_COMMAS + 1);
    localparam int EW = $clog2(LOSS_ERRORS + 1);
    localparam logic [CW-1:0] COMMA_MAX  = CW'(LOCK_COMMAS);
    localparam logic [CW-1:0] COMMA_LAST = CW'(LOCK_COMMAS - 1);
    localparam logic [EW-1:0] ERR_MAX    = EW'(LOSS_ERRORS);
    localparam logic [EW-1:0] ERR_LAST   = EW'(LOSS_ERRORS - 1);

    logic [9:0]    window;
    logic [9:0]    win_next;
    logic [3:0]    phase;
    state_t        state;
    logic [CW-1:0] comma_cnt;
    logic [EW-1:0] err_cnt;
    logic          rd;
    logic          boundary;
    logic          chk_rd_next;
    logic          chk_err;
    logic          chk_comma;

    // all decisions look at the window including the bit being sampled now
    assign win_next = {window[8:0], bit_in};
    assign boundary = (phase == 4'd9);

    comma_aligner_10b_sym_disparity_chk u_chk (
        .sym      (win_next),
        .rd       (rd),
        .rd_next  (chk_rd_next),
        .code_err (chk_err),
        .is_comma (chk_comma)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            window    <= '0;
            phase     <= '0;
            state     <= HUNT;
            comma_cnt <= '0;
            err_cnt   <= '0;
            rd        <= 1'b0;
            sym_out   <= '0;
            rd_out    <= 1'b0;
            sym_valid <= 1'b0;
            is_comma  <= 1'b0;
            code_err  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            if (bit_valid) begin
                window <= win_next;
                phase  <= boundary ? 4'd0 : phase + 4'd1;
                case (state)
                    HUNT: begin
                        if (chk_comma) begin
                            // comma just completed, so the next bit opens a symbol;
                            // rd is the disparity after the comma
                            phase     <= 4'd0;
                            rd        <= (win_next == K28_5_NEG);
                            comma_cnt <= CW'(1);
                            state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (boundary) begin
                            if (chk_err) begin
                                state <= HUNT;
                            end else begin
                                rd <= chk_rd_next;
                                if (chk_comma) begin
                                    if (comma_cnt >= COMMA_LAST) begin
                                        comma_cnt <= COMMA_MAX;
                                        err_cnt   <= '0;
                                        state     <= LOCKED;
                                        locked    <= 1'b1;
                                        sym_valid <= 1'b1;
                                        sym_out   <= win_next;
                                        rd_out    <= rd;
                                        is_comma  <= 1'b1;
                                        code_err  <= 1'b0;
                                    end else begin
                                        comma_cnt <= comma_cnt + CW'(1);
                                    end
                                end
                            end
                        end else if (chk_comma) begin
                            // comma at a new phase: re-anchor and start counting again
                            phase     <= 4'd0;
                            rd        <= (win_next == K28_5_NEG);
                            comma_cnt <= CW'(1);
                        end
                    end
                    LOCKED: begin
                        if (boundary) begin
                            sym_valid <= 1'b1;
                            sym_out   <= win_next;
                            rd_out    <= rd;
                            is_comma  <= chk_comma;
                            code_err  <= chk_err;
                            rd        <= chk_rd_next;
                            if (chk_err) begin
                                if (err_cnt >= ERR_LAST) begin
                                    err_cnt <= ERR_MAX;
                                    state   <= HUNT;
                                    locked  <= 1'b0;
                                end else begin
                                    err_cnt <= err_cnt + EW'(1);
                                end
                            end else begin
                                err_cnt <= '0;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_comma_aligner_10b.sv
// tb/tb_comma_aligner_10b.sv - self-checking bench for comma_aligner_10b
module tb_comma_aligner_10b;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic [9:0] sym_out;
    logic       rd_out;
    logic       sym_valid;
    logic       is_comma;
    logic       code_err;
    logic       locked;

    comma_aligner_10b #(.LOCK_COMMAS(3), .LOSS_ERRORS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sym_out   (sym_out),
        .rd_out    (rd_out),
        .sym_valid (sym_valid),
        .is_comma  (is_comma),
        .code_err  (code_err),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [9:0] KN  = 10'b0011111010;
    localparam logic [9:0] KP  = 10'b1100000101;
    localparam logic [9:0] D21 = 10'b1010101010;
    localparam logic [9:0] ALL1 = 10'b1111111111;
    localparam logic [9:0] ALL0 = 10'b0000000000;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // behavioural model: line history, symbol position, signed disparity
    bit hist[$];
    int m_st;   // 0 hunt, 1 verify, 2 locked
    int m_pos;  // bits already received of the current symbol
    int m_rd;   // 0 = RD-, 1 = RD+
    int m_cc;
    int m_ec;
    int e_valid, e_locked, e_rst, e_sym, e_rd, e_cm, e_er;

    int log_sym[$];
    int log_rd[$];
    int log_cm[$];
    int log_er[$];

    task automatic model_step();
        int w, ones, disp, nrd;
        bit cm, legal, bnd;
        e_valid = 0;
        e_rst   = 0;
        if (!rst) begin
            hist.delete();
            m_st = 0; m_pos = 0; m_rd = 0; m_cc = 0; m_ec = 0;
            e_locked = 0; e_rst = 1;
            e_sym = 0; e_rd = 0; e_cm = 0; e_er = 0;
            return;
        end
        if (!bit_valid) return;
        hist.push_back(bit_in);
        if (hist.size() > 10) void'(hist.pop_front());
        w = 0;
        ones = 0;
        foreach (hist[i]) begin
            w = w * 2 + int'(hist[i]);
            ones += int'(hist[i]);
        end
        cm    = (w == int'(KN)) || (w == int'(KP));
        disp  = 2 * ones - 10;
        legal = (disp == 0) || (disp == 2 && m_rd == 0) || (disp == -2 && m_rd == 1);
        nrd   = (disp == 2) ? 1 : (disp == -2) ? 0 : m_rd;
        bnd   = (m_pos == 9);
        m_pos = (m_pos + 1) % 10;
        if (m_st == 0) begin
            if (cm) begin
                m_pos = 0; m_rd = (w == int'(KN)) ? 1 : 0; m_cc = 1; m_st = 1;
            end
        end else if (m_st == 1) begin
            if (bnd) begin
                if (!legal) m_st = 0;
                else begin
                    if (cm) begin
                        m_cc++;
                        if (m_cc >= 3) begin
                            m_st = 2; m_ec = 0;
                            e_valid = 1; e_sym = w; e_rd = m_rd; e_cm = 1; e_er = 0;
                        end
                    end
                    m_rd = nrd;
                end
            end else if (cm) begin
                m_pos = 0; m_rd = (w == int'(KN)) ? 1 : 0; m_cc = 1;
            end
        end else begin
            if (bnd) begin
                e_valid = 1; e_sym = w; e_rd = m_rd; e_cm = cm; e_er = !legal;
                m_rd = nrd;
                if (!legal) begin
                    m_ec++;
                    if (m_ec >= 4) m_st = 0;
                end else m_ec = 0;
            end
        end
        e_locked = (m_st == 2);
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("sym_valid", sym_valid, e_valid);
        chk("locked", locked, e_locked);
        if (e_valid != 0 || e_rst != 0) begin
            chk("sym_out", sym_out, e_sym);
            chk("rd_out", rd_out, e_rd);
            chk("is_comma", is_comma, e_cm);
            chk("code_err", code_err, e_er);
        end
        if (sym_valid) begin
            log_sym.push_back(int'(sym_out));
            log_rd.push_back(int'(rd_out));
            log_cm.push_back(int'(is_comma));
            log_er.push_back(int'(code_err));
        end
    end

    task automatic send_bit(input logic b, input bit gap);
        @(negedge clk);
        bit_in = b;
        bit_valid = 1'b1;
        if (gap) begin
            @(negedge clk);
            bit_valid = 1'b0;
            bit_in = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_sym(input logic [9:0] s, input bit gap);
        for (int i = 9; i >= 0; i--) send_bit(s[i], gap);
    endtask

    task automatic settle();
        @(negedge clk);
        bit_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'($urandom_range(0, 1));
            bit_valid = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        bit_valid = 1'b0;
    endtask

    task automatic lock_stream(input bit gap);
        send_bit(1'b1, gap);
        send_bit(1'b0, gap);
        send_bit(1'b1, gap);
        send_sym(KN, gap);
        send_sym(KP, gap);
        settle();
        chk("no_lock_before_third_comma", locked, 0);
        send_sym(KN, gap);
        settle();
    endtask

    int base;

    initial begin
        rst = 1'b0;
        bit_in = 1'b0;
        bit_valid = 1'b0;

        do_reset();
        chk("reset_locked", locked, 0);
        chk("reset_sym_valid", sym_valid, 0);
        chk("reset_sym_out", sym_out, 0);

        // initial lock
        base = log_sym.size();
        lock_stream(1'b0);
        chk("lock_locked", locked, 1);
        chk("lock_strobes", log_sym.size() - base, 1);
        if (log_sym.size() == base + 1) begin
            chk("lock_sym", log_sym[base], 10'h0FA);
            chk("lock_rd", log_rd[base], 0);
            chk("lock_comma", log_cm[base], 1);
        end

        // neutral data after lock
        base = log_sym.size();
        send_sym(D21, 1'b0);
        send_sym(D21, 1'b0);
        settle();
        chk("d21_strobes", log_sym.size() - base, 2);
        if (log_sym.size() == base + 2) begin
            for (int i = 0; i < 2; i++) begin
                chk("d21_sym", log_sym[base + i], 10'h2AA);
                chk("d21_rd", log_rd[base + i], 1);
                chk("d21_err", log_er[base + i], 0);
            end
        end

        // loss of lock
        base = log_sym.size();
        for (int i = 0; i < 3; i++) send_sym(ALL1, 1'b0);
        settle();
        chk("loss_still_locked", locked, 1);
        send_sym(ALL1, 1'b0);
        settle();
        chk("loss_strobes", log_sym.size() - base, 4);
        if (log_sym.size() == base + 4) begin
            for (int i = 0; i < 4; i++) chk("loss_err", log_er[base + i], 1);
        end
        chk("loss_unlocked", locked, 0);
        base = log_sym.size();
        send_sym(D21, 1'b0);
        send_sym(D21, 1'b0);
        settle();
        chk("hunt_silent", log_sym.size() - base, 0);

        // verify failure then relock
        base = log_sym.size();
        send_sym(KN, 1'b0);
        send_sym(ALL0, 1'b0);
        settle();
        chk("verify_fail_unlocked", locked, 0);
        send_sym(KN, 1'b0);
        send_sym(KP, 1'b0);
        settle();
        chk("verify_second_unlocked", locked, 0);
        chk("verify_silent", log_sym.size() - base, 0);
        send_sym(KN, 1'b0);
        settle();
        chk("relock_locked", locked, 1);
        chk("relock_strobes", log_sym.size() - base, 1);
        if (log_sym.size() == base + 1) begin
            chk("relock_sym", log_sym[base], 10'h0FA);
            chk("relock_rd", log_rd[base], 0);
        end

        // reset while locked, then lock with bit_valid gaps
        do_reset();
        chk("midlock_reset_locked", locked, 0);
        base = log_sym.size();
        lock_stream(1'b1);
        chk("gap_locked", locked, 1);
        chk("gap_strobes", log_sym.size() - base, 1);
        if (log_sym.size() == base + 1) begin
            chk("gap_sym", log_sym[base], 10'h0FA);
            chk("gap_rd", log_rd[base], 0);
            chk("gap_comma", log_cm[base], 1);
        end
        base = log_sym.size();
        send_sym(D21, 1'b1);
        settle();
        chk("gap_d21_strobes", log_sym.size() - base, 1);
        if (log_sym.size() == base + 1) chk("gap_d21_rd", log_rd[base], 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
